// File: rtl/jedro_1_imem_pkg.sv
// Shared constants and types for the jedro_1 instruction memory.
package jedro_1_defines;
    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000;
    localparam logic [DATA_WIDTH-1:0] JEDRO_1_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        IMEM_RUN  = 1'b0,
        IMEM_LOAD = 1'b1
    } imem_state_e;
endpackage

// File: rtl/ram_read_io.sv
// Simple read-only memory bus: byte address out, data word back one cycle later.
interface ram_read_io;
    import jedro_1_defines::*;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;

    modport MASTER (output addr, input rdata);
    modport SLAVE  (input addr, output rdata);
endinterface

// File: rtl/jedro_1_imem_sprom.sv
// Word array with one write port and a registered read port; contents are never reset.
module jedro_1_sprom #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/jedro_1_imem.sv
// Instruction memory with run-time byte loader. Optional JEDRO_1_IMEM_BOUNDS_CHECK_EN
// adds fetch_err_o and returns NOP for misaligned or out-of-range fetches.
module jedro_1_imem
    import jedro_1_defines::*;
#(
    parameter int                    MEM_DEPTH_WORDS = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR       = BOOT_ADDR,
    parameter logic [DATA_WIDTH-1:0] INIT_NOP        = JEDRO_1_NOP_INSTR
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    ram_read_io.SLAVE                          instr_mem_if,
    input  logic                               load_start_i,
    input  logic [7:0]                         load_byte_i,
    input  logic                               load_byte_valid_i,
    output logic                               load_byte_ready_o,
    input  logic                               load_last_i,
    output logic                               load_done_o,
    output logic                               load_err_o,
    output logic [$clog2(MEM_DEPTH_WORDS):0]   load_words_o,
`ifdef JEDRO_1_IMEM_BOUNDS_CHECK_EN
    output logic                               fetch_err_o,
`endif
    output logic                               core_hold_o
);
    localparam int AW = $clog2(MEM_DEPTH_WORDS);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH_WORDS);

    imem_state_e           state_reg;
    logic [AW:0]           ptr_reg;
    logic [1:0]            bcnt_reg;
    logic [23:0]           word_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic [AW:0]           words_reg;
    logic                  nop_sel_reg;

    logic                  accept;
    logic                  full_write;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  fetch_bad;
    logic                  unused_bits;

    assign load_byte_ready_o = (state_reg == IMEM_LOAD);
    assign core_hold_o       = (state_reg == IMEM_LOAD);
    assign load_done_o       = done_reg;
    assign load_err_o        = err_reg;
    assign load_words_o      = words_reg;

    // A restart in the same cycle as a handshake discards that byte.
    assign accept     = load_byte_ready_o & load_byte_valid_i & ~load_start_i;
    assign full_write = accept & ((bcnt_reg == 2'd3) | load_last_i);
    assign we         = full_write & (ptr_reg != DEPTH_W);

    // Partial words on the last byte are zero-padded in the upper lanes.
    always_comb begin
        wdata = '0;
        case (bcnt_reg)
            2'd0:    wdata = {24'd0, load_byte_i};
            2'd1:    wdata = {16'd0, load_byte_i, word_reg[7:0]};
            2'd2:    wdata = {8'd0, load_byte_i, word_reg[15:0]};
            default: wdata = {load_byte_i, word_reg};
        endcase
    end

    assign offset = instr_mem_if.addr - BASE_ADDR;

`ifdef JEDRO_1_IMEM_BOUNDS_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * MEM_DEPTH_WORDS);
    logic fetch_err_reg;

    assign fetch_bad   = (instr_mem_if.addr < BASE_ADDR) | (offset >= SPAN)
                       | (instr_mem_if.addr[1:0] != 2'b00);
    assign unused_bits = ^offset[1:0];
    assign fetch_err_o = fetch_err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_err_reg <= 1'b0;
        end else begin
            fetch_err_reg <= (state_reg == IMEM_RUN) & fetch_bad;
        end
    end
`else
    assign fetch_bad   = 1'b0;
    assign unused_bits = ^{offset[DATA_WIDTH-1:AW+2], offset[1:0]};
`endif

    jedro_1_sprom #(
        .DEPTH (MEM_DEPTH_WORDS),
        .AW    (AW),
        .DW    (DATA_WIDTH)
    ) u_sprom (
        .clk   (clk_i),
        .we    (we),
        .waddr (ptr_reg[AW-1:0]),
        .wdata (wdata),
        .raddr (offset[AW+1:2]),
        .rdata (mem_q)
    );

    // NOP select is registered alongside the array read so both refer to the same fetch.
    assign instr_mem_if.rdata = nop_sel_reg ? INIT_NOP : mem_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IMEM_RUN;
            ptr_reg     <= '0;
            bcnt_reg    <= '0;
            word_reg    <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            words_reg   <= '0;
            nop_sel_reg <= 1'b1;
        end else begin
            done_reg    <= 1'b0;
            nop_sel_reg <= (state_reg == IMEM_LOAD) | fetch_bad;
            if (load_start_i) begin
                state_reg <= IMEM_LOAD;
                ptr_reg   <= '0;
                bcnt_reg  <= '0;
                word_reg  <= '0;
                err_reg   <= 1'b0;
            end else if (accept) begin
                if (full_write) begin
                    bcnt_reg <= '0;
                    word_reg <= '0;
                    if (we) begin
                        ptr_reg <= ptr_reg + (AW+1)'(1);
                    end else begin
                        err_reg <= 1'b1;
                    end
                end else begin
                    bcnt_reg <= bcnt_reg + 2'd1;
                    word_reg[{bcnt_reg, 3'b000} +: 8] <= load_byte_i;
                end
                if (load_last_i) begin
                    state_reg <= IMEM_RUN;
                    done_reg  <= 1'b1;
                    words_reg <= we ? ptr_reg + (AW+1)'(1) : ptr_reg;
                end
            end
        end
    end
endmodule

// File: tb/tb_jedro_1_imem.sv
// Directed bench for jedro_1_imem with a small array (8 words) at a non-zero base.
module tb_jedro_1_imem;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic [7:0] load_byte = 8'h00;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic       load_last = 1'b0;
    logic       load_done;
    logic       load_err;
    logic [3:0] load_words;
    logic       core_hold;
`ifdef JEDRO_1_IMEM_BOUNDS_CHECK_EN
    logic       fetch_err;
`endif

    int total = 0;
    int bad   = 0;

    ram_read_io imem_if ();

    jedro_1_imem #(
        .MEM_DEPTH_WORDS (DEPTH),
        .BASE_ADDR       (BASE)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .instr_mem_if      (imem_if),
        .load_start_i      (load_start),
        .load_byte_i       (load_byte),
        .load_byte_valid_i (load_valid),
        .load_byte_ready_o (load_ready),
        .load_last_i       (load_last),
        .load_done_o       (load_done),
        .load_err_o        (load_err),
        .load_words_o      (load_words),
`ifdef JEDRO_1_IMEM_BOUNDS_CHECK_EN
        .fetch_err_o       (fetch_err),
`endif
        .core_hold_o       (core_hold)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Offers one byte with optional idle gap before it; waits (bounded) for ready.
    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) tick();
        load_byte  = b;
        load_last  = last;
        load_valid = 1'b1;
        waited = 0;
        while (load_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("ready_timeout", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        imem_if.addr = a;
        tick();
        d = imem_if.rdata;
        $display("read addr=%h rdata=%h", a, d);
    endtask

    task automatic load_five(input int gapmax);
        logic [7:0] bytes5 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        start_load();
        for (int i = 0; i < 5; i++) send_byte(bytes5[i], i == 4, $urandom_range(0, gapmax));
        $display("load five bytes gapmax=%0d words=%0d", gapmax, load_words);
        check("five_done", {31'd0, load_done}, 32'd1);
        check("five_words", {28'd0, load_words}, 32'd2);
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  prog [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

        imem_if.addr = BASE;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rdata", imem_if.rdata, NOP);
        check("rst_hold", {31'd0, core_hold}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_ready", {31'd0, load_ready}, 32'd0);
        check("rst_words", {28'd0, load_words}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        tick();
        tick();

        // Two-word program
        start_load();
        check("load_hold", {31'd0, core_hold}, 32'd1);
        check("load_ready", {31'd0, load_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i], i == 7, 0);
            if (i == 2) check("load_rdata_nop", imem_if.rdata, NOP);
        end
        $display("load prog done=%0b words=%0d", load_done, load_words);
        check("prog_done", {31'd0, load_done}, 32'd1);
        check("prog_hold", {31'd0, core_hold}, 32'd0);
        check("prog_words", {28'd0, load_words}, 32'd2);
        rd(BASE, d);
        check("prog_done_pulse", {31'd0, load_done}, 32'd0);
        check("prog_w0", d, 32'h0010_0513);
        rd(BASE + 32'd4, d);
        check("prog_w1", d, 32'h0020_0593);

        // Partial final word, without and with valid gaps
        load_five(0);
        rd(BASE, d);       check("five_w0", d, 32'hDDCC_BBAA);
        rd(BASE + 4, d);   check("five_w1", d, 32'h0000_00EE);
        load_five(3);
        rd(BASE, d);       check("gap_w0", d, 32'hDDCC_BBAA);
        rd(BASE + 4, d);   check("gap_w1", d, 32'h0000_00EE);

        // Overflow: DEPTH*4+4 bytes, byte value = index
        start_load();
        for (int i = 0; i < DEPTH * 4 + 4; i++) begin
            if (i == DEPTH * 4) check("ovf_err_before", {31'd0, load_err}, 32'd0);
            if (i == DEPTH * 4 + 3) check("ovf_ready", {31'd0, load_ready}, 32'd1);
            send_byte(8'(i), i == DEPTH * 4 + 3, 0);
        end
        $display("load overflow err=%0b words=%0d", load_err, load_words);
        check("ovf_err", {31'd0, load_err}, 32'd1);
        check("ovf_words", {28'd0, load_words}, 32'd8);
        rd(BASE, d);
        check("ovf_err_sticky", {31'd0, load_err}, 32'd1);
        check("ovf_w0", d, 32'h0302_0100);
        rd(BASE + 28, d);  check("ovf_w7", d, 32'h1F1E_1D1C);

        // Reset in the middle of a load
        start_load();
        check("restart_clears_err", {31'd0, load_err}, 32'd0);
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("reset mid-load hold=%0b", core_hold);
        check("mid_rst_hold", {31'd0, core_hold}, 32'd0);
        check("mid_rst_ready", {31'd0, load_ready}, 32'd0);
        check("mid_rst_rdata", imem_if.rdata, NOP);
        check("mid_rst_words", {28'd0, load_words}, 32'd0);
        rd(BASE, d);       check("mid_rst_w0", d, 32'h1413_1211);
        rd(BASE + 4, d);   check("mid_rst_w1", d, 32'h0706_0504);

        // Start with a byte in RUN, then restart colliding with a last byte
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'h99;
        check("start_run_ready", {31'd0, load_ready}, 32'd0);
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'h66, 1'b0, 0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_byte  = 8'h77;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        $display("restart collides with last byte hold=%0b done=%0b", core_hold, load_done);
        check("collide_no_done", {31'd0, load_done}, 32'd0);
        check("collide_hold", {31'd0, core_hold}, 32'd1);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        send_byte(8'h04, 1'b1, 0);
        check("collide_done", {31'd0, load_done}, 32'd1);
        check("collide_words", {28'd0, load_words}, 32'd1);
        rd(BASE, d);       check("collide_w0", d, 32'h0403_0201);
        rd(BASE + 4, d);   check("collide_w1", d, 32'h0706_0504);

        // Out-of-range and misaligned fetches
`ifdef JEDRO_1_IMEM_BOUNDS_CHECK_EN
        rd(BASE + 2, d);
        check("bc_misal_rdata", d, NOP);
        check("bc_misal_err", {31'd0, fetch_err}, 32'd1);
        rd(BASE + 4 * DEPTH, d);
        check("bc_high_rdata", d, NOP);
        check("bc_high_err", {31'd0, fetch_err}, 32'd1);
        rd(BASE - 4, d);
        check("bc_low_rdata", d, NOP);
        check("bc_low_err", {31'd0, fetch_err}, 32'd1);
        rd(BASE + 4, d);
        check("bc_ok_rdata", d, 32'h0706_0504);
        check("bc_ok_err", {31'd0, fetch_err}, 32'd0);
`else
        rd(BASE + 2, d);         check("wrap_misal", d, 32'h0403_0201);
        rd(BASE + 4 * DEPTH, d); check("wrap_high", d, 32'h0403_0201);
        rd(BASE - 4, d);         check("wrap_low", d, 32'h1F1E_1D1C);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
